change_dispenser: RTL and testbench
===================================

# change_dispenser

Hopper-side counterpart of the vending controller's change path: takes the change amount the controller presents on its 16-bit change output and pays it out as individual physical coins. Uses a greedy largest-coin-first order, tracks a per-denomination coin inventory, and drives a one-coin-at-a-time valid/ready handshake toward the coin hopper. Reports completion, or a fault plus the unpaid residual when exact change is impossible.

## Interface
- INIT_COUNT, default 8'd20: coins of each denomination loaded into inventory at reset.
- CNT_W, default 8: inventory counter width; counts saturate at 2^CNT_W-1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- change_in  in  16  amount to pay out, in cents; a nonzero value while IDLE is a request.
- coin_ready  in  1  hopper accepts the coin on coin_out this cycle.
- refill_en  in  1  add refill_cnt coins to inventory of refill_denom.
- refill_denom  in  3  denomination index 0..4 = 10, 20, 50, 100, 200; values 5..7 are ignored.
- refill_cnt  in  CNT_W  number of coins to add.
- coin_out  out  16  denomination of the offered coin (10/20/50/100/200), 0 when not offering.
- coin_valid  out  1  coin_out is offered to the hopper.
- busy  out  1  request in progress (any state other than IDLE).
- done  out  1  one-cycle pulse: full amount paid.
- fault  out  1  one-cycle pulse: payout aborted.
- residual_out  out  16  unpaid amount after a fault; held until the next request is accepted.

## Operation
- States: IDLE, SELECT, ISSUE, DONE, FAULT (enum in the package).
- IDLE: if change_in != 0, latch remaining <= change_in, clear residual_out, go to SELECT. Otherwise stay. Zero is never a request.
- SELECT:
  - remaining == 0 -> DONE.
  - Otherwise pick the largest denomination d with d <= remaining and count[d] > 0. If found: coin_out <= d, coin_valid <= 1, go to ISSUE.
  - If none exists (remaining not a multiple of 10, or inventory exhausted) -> FAULT, residual_out <= remaining.
- ISSUE: hold coin_valid = 1 and coin_out stable until coin_ready = 1. On that edge the transfer happens: remaining <= remaining - d, count[d] decremented, coin_valid <= 0, coin_out <= 0, go to SELECT.
- DONE: done = 1 for one cycle, then IDLE. FAULT: fault = 1 for one cycle, then IDLE.
- change_in is ignored while busy. Requests are not queued.
- Refill: on refill_en, count[refill_denom] <= min(count + refill_cnt, max). When a refill and a dispense of the same denomination happen on the same edge, apply net count - 1 + refill_cnt, saturated at max.
- Arithmetic: remaining is unsigned 16-bit. Subtraction never underflows because d <= remaining is guaranteed by SELECT.

## Timing
- Reset values: coin_out 0, coin_valid 0, busy 0, done 0, fault 0, residual_out 0, state IDLE, remaining 0, every count INIT_COUNT.
- Reset mid-payout: abandons the request immediately. Coins already transferred are not restored to inventory.
- All outputs are registered.
- Request sampled at edge k -> SELECT after k -> coin_valid high after edge k+1.
- Each coin takes at least 2 cycles (ISSUE to SELECT to ISSUE). With coin_ready tied high, n coins complete by edge k+2n, and done is high after edge k+2n+1.
- coin_ready is don't-care while coin_valid = 0.

## Structure
- Shared package vend_pkg holds:
  - denomination constants (10, 20, 50, 100, 200) and the index encoding;
  - the change_dispenser state enum;
  - the 16-bit amount type shared with the vending controller.
- One sub-module, denom_select: combinational greedy picker. Inputs are remaining and the five count-nonzero flags; outputs are a found flag, the denomination index and the denomination value. Everything else lives in change_dispenser.

## Test plan
- change_in = 380, full inventory, coin_ready = 1: coin_out sequence 200, 100, 50, 20, 10; done pulses once; residual_out = 0; each count decremented by 1.
- change_in = 40 after refill-free drain of count[20] to 0: sequence 10, 10, 10, 10; done.
- change_in = 15: one 10 coin issued, then fault pulse with residual_out = 5 held until the next request.
- Backpressure: coin_ready low for 3 cycles on the first coin of 50. coin_valid stays high with coin_out = 50 constant; the transfer happens only on the ready edge.
- change_in changed to 100 while busy: ignored, the current payout is unaffected. Refill of 255 into index 4 at count 20 saturates at 255; refill_denom = 6 has no effect.
- rst asserted during ISSUE: outputs return to reset values asynchronously; state is IDLE; counts return to INIT_COUNT.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending types: the amount type, coin denominations with their index
// encoding, and the change_dispenser state encoding.
package vend_pkg;

  typedef logic [15:0] amount_t;

  localparam int NUM_DENOM = 5;

  localparam logic [2:0] IDX_10  = 3'd0;
  localparam logic [2:0] IDX_20  = 3'd1;
  localparam logic [2:0] IDX_50  = 3'd2;
  localparam logic [2:0] IDX_100 = 3'd3;
  localparam logic [2:0] IDX_200 = 3'd4;

  localparam amount_t DENOM_10  = 16'd10;
  localparam amount_t DENOM_20  = 16'd20;
  localparam amount_t DENOM_50  = 16'd50;
  localparam amount_t DENOM_100 = 16'd100;
  localparam amount_t DENOM_200 = 16'd200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE,
    ST_FAULT
  } disp_state_t;

  // Unused indices map to 0 so they can never be selected.
  function automatic amount_t denom_value(input logic [2:0] idx);
    case (idx)
      IDX_10:  denom_value = DENOM_10;
      IDX_20:  denom_value = DENOM_20;
      IDX_50:  denom_value = DENOM_50;
      IDX_100: denom_value = DENOM_100;
      IDX_200: denom_value = DENOM_200;
      default: denom_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/denom_select.sv
// Greedy picker: the largest stocked denomination not exceeding the amount
// still owed.
module denom_select
  import vend_pkg::*;
(
  input  amount_t                remaining,
  input  logic [NUM_DENOM-1:0]   avail,
  output logic                   found,
  output logic [2:0]             idx,
  output amount_t                value
);

  // Ascending scan; the last qualifying denomination (the largest) wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    value = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (avail[i] && (denom_value(3'(i)) <= remaining)) begin
        found = 1'b1;
        idx   = 3'(i);
        value = denom_value(3'(i));
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time toward the hopper, largest coin
// first, while tracking a saturating per-denomination inventory.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int              CNT_W      = 8,
  parameter logic [CNT_W-1:0] INIT_COUNT = 8'd20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      change_in,
  input  logic             coin_ready,
  input  logic             refill_en,
  input  logic [2:0]       refill_denom,
  input  logic [CNT_W-1:0] refill_cnt,
  output logic [15:0]      coin_out,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [15:0]      residual_out
);

  disp_state_t      state_reg, state_next;
  amount_t          remaining_reg, remaining_next;
  amount_t          coin_out_reg, coin_out_next;
  amount_t          residual_reg, residual_next;
  logic [2:0]       idx_reg, idx_next;
  logic             coin_valid_reg, coin_valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             fault_reg, fault_next;
  logic [CNT_W-1:0] count_reg [NUM_DENOM];
  logic [CNT_W-1:0] count_next [NUM_DENOM];

  logic [NUM_DENOM-1:0] avail;
  logic                 sel_found;
  logic [2:0]           sel_idx;
  amount_t              sel_value;
  logic                 take;

  assign take = (state_reg == ST_ISSUE) && coin_ready;

  denom_select u_denom_select (
    .remaining (remaining_reg),
    .avail     (avail),
    .found     (sel_found),
    .idx       (sel_idx),
    .value     (sel_value)
  );

  // Refill and dispense of the same denomination on one edge net together
  // before saturating; a dispense only happens from a nonzero count.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DENOM; gi++) begin : g_count
      logic           inc;
      logic           dec;
      logic [CNT_W:0] sum;
      assign inc = refill_en && (refill_denom == 3'(gi));
      assign dec = take && (idx_reg == 3'(gi));
      assign sum = {1'b0, count_reg[gi]} + (inc ? {1'b0, refill_cnt} : '0)
                 - {{CNT_W{1'b0}}, dec};
      assign count_next[gi] = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      assign avail[gi]      = |count_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    remaining_next  = remaining_reg;
    coin_out_next   = coin_out_reg;
    residual_next   = residual_reg;
    idx_next        = idx_reg;
    coin_valid_next = coin_valid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (change_in != '0) begin
          remaining_next = change_in;
          residual_next  = '0;
          state_next     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining_reg == '0) begin
          state_next = ST_DONE;
        end else if (sel_found) begin
          coin_out_next   = sel_value;
          idx_next        = sel_idx;
          coin_valid_next = 1'b1;
          state_next      = ST_ISSUE;
        end else begin
          residual_next = remaining_reg;
          state_next    = ST_FAULT;
        end
      end
      ST_ISSUE: begin
        if (coin_ready) begin
          remaining_next  = remaining_reg - coin_out_reg;
          coin_out_next   = '0;
          coin_valid_next = 1'b0;
          state_next      = ST_SELECT;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    busy_next  = (state_next != ST_IDLE);
    done_next  = (state_next == ST_DONE);
    fault_next = (state_next == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      remaining_reg  <= '0;
      coin_out_reg   <= '0;
      residual_reg   <= '0;
      idx_reg        <= '0;
      coin_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      fault_reg      <= 1'b0;
      for (int i = 0; i < NUM_DENOM; i++) count_reg[i] <= INIT_COUNT;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      coin_out_reg   <= coin_out_next;
      residual_reg   <= residual_next;
      idx_reg        <= idx_next;
      coin_valid_reg <= coin_valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      fault_reg      <= fault_next;
      count_reg      <= count_next;
    end
  end

  assign coin_out     = coin_out_reg;
  assign coin_valid   = coin_valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign fault        = fault_reg;
  assign residual_out = residual_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin sequences, timing, backpressure,
// faults, refill saturation and asynchronous reset.
module tb_change_dispenser;
  import vend_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] change_in;
  logic        coin_ready;
  logic        refill_en;
  logic [2:0]  refill_denom;
  logic [7:0]  refill_cnt;
  logic [15:0] coin_out;
  logic        coin_valid;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] residual_out;

  change_dispenser #(.CNT_W(8), .INIT_COUNT(8'd20)) dut (
    .clk          (clk),
    .rst          (rst),
    .change_in    (change_in),
    .coin_ready   (coin_ready),
    .refill_en    (refill_en),
    .refill_denom (refill_denom),
    .refill_cnt   (refill_cnt),
    .coin_out     (coin_out),
    .coin_valid   (coin_valid),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .residual_out (residual_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned coins[$];
  int unsigned exp_seq[$];
  int unsigned exp_cnt[5];
  int          done_cnt, fault_cnt, end_cyc, first_valid;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_seq(input string tag);
    int n;
    check_val({tag, "_len"}, coins.size(), exp_seq.size());
    n = (coins.size() < exp_seq.size()) ? coins.size() : exp_seq.size();
    for (int i = 0; i < n; i++) check_val($sformatf("%s_coin%0d", tag, i), coins[i], exp_seq[i]);
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < 5; i++)
      check_val($sformatf("%s_cnt%0d", tag, i), dut.count_reg[i], exp_cnt[i]);
  endtask

  // One request: amt is presented for one edge, then busy_val is driven while
  // the payout runs. The first coin is held off for 'stall' cycles.
  task automatic run_req(input logic [15:0] amt, input int stall,
                         input logic [15:0] busy_val, input logic [15:0] stall_coin);
    int stall_left;
    coins.delete();
    done_cnt = 0; fault_cnt = 0; end_cyc = 0; first_valid = 0;
    stall_left = stall;
    @(negedge clk);
    change_in  = amt;
    coin_ready = (stall == 0);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      change_in = busy_val;
      if (cyc == 1) check_val("busy_rise", busy, 1);
      if (coin_valid) begin
        if (stall_left > 0) begin
          check_val("stall_coin", coin_out, stall_coin);
          stall_left--;
          coin_ready = 1'b0;
        end else begin
          coin_ready = 1'b1;
        end
      end
      if (coin_valid && first_valid == 0) first_valid = cyc;
      if (coin_valid && coin_ready) coins.push_back(coin_out);
      if (done) done_cnt++;
      if (fault) fault_cnt++;
      if (done || fault) begin
        end_cyc = cyc;
        break;
      end
    end
    if (end_cyc == 0) check_val("timeout", 1, 0);
    @(negedge clk);
    change_in = '0;
    check_val("pulse_low", {30'd0, done, fault}, 0);
    check_val("busy_fall", busy, 0);
    $display("req amt=%0d coins=%0d done=%0d fault=%0d residual=%0d cycles=%0d",
             amt, coins.size(), done_cnt, fault_cnt, residual_out, end_cyc);
  endtask

  task automatic do_refill(input logic [2:0] d, input logic [7:0] n);
    @(negedge clk);
    refill_en = 1'b1; refill_denom = d; refill_cnt = n;
    @(negedge clk);
    refill_en = 1'b0;
    $display("refill denom=%0d cnt=%0d", d, n);
  endtask

  initial begin
    rst = 1'b1; change_in = '0; coin_ready = 1'b0;
    refill_en = 1'b0; refill_denom = '0; refill_cnt = '0;
    repeat (2) @(negedge clk);
    check_val("rst_coin_out", coin_out, 0);
    check_val("rst_valid", coin_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_residual", residual_out, 0);
    exp_cnt = '{20, 20, 20, 20, 20};
    check_counts("rst");
    rst = 1'b0;

    // Full greedy sequence with ready tied high
    exp_seq = '{200, 100, 50, 20, 10};
    run_req(16'd380, 0, 16'd0, 16'd0);
    check_seq("g380");
    check_val("g380_done", done_cnt, 1);
    check_val("g380_fault", fault_cnt, 0);
    check_val("g380_first_valid", first_valid, 2);
    check_val("g380_done_cyc", end_cyc, 12);
    check_val("g380_residual", residual_out, 0);
    exp_cnt = '{19, 19, 19, 19, 19};
    check_counts("g380");

    // Drain the 20s, then 40 must come out as four 10s
    for (int i = 0; i < 19; i++) run_req(16'd20, 0, 16'd0, 16'd0);
    check_val("drain20", dut.count_reg[1], 0);
    exp_seq = '{10, 10, 10, 10};
    run_req(16'd40, 0, 16'd0, 16'd0);
    check_seq("g40");
    check_val("g40_done", done_cnt, 1);
    check_val("g40_cnt10", dut.count_reg[0], 15);

    // Inexact amount: one 10, then fault with 5 left over
    exp_seq = '{10};
    run_req(16'd15, 0, 16'd0, 16'd0);
    check_seq("g15");
    check_val("g15_fault", fault_cnt, 1);
    check_val("g15_done", done_cnt, 0);
    check_val("g15_fault_cyc", end_cyc, 4);
    check_val("g15_residual", residual_out, 5);
    repeat (3) @(negedge clk);
    check_val("g15_residual_hold", residual_out, 5);

    // Backpressure on a 50, with change_in switched to 100 while busy
    exp_seq = '{50};
    run_req(16'd50, 3, 16'd100, 16'd50);
    check_seq("bp50");
    check_val("bp50_done", done_cnt, 1);
    check_val("bp50_done_cyc", end_cyc, 7);
    check_val("bp50_residual_clr", residual_out, 0);
    check_val("bp50_cnt50", dut.count_reg[2], 18);
    repeat (3) @(negedge clk);
    check_val("bp50_no_requeue", busy, 0);

    // Refill: saturation, plain add, out-of-range index
    do_refill(3'd4, 8'd255);
    check_val("refill_sat", dut.count_reg[4], 255);
    do_refill(3'd1, 8'd3);
    check_val("refill_add", dut.count_reg[1], 3);
    do_refill(3'd6, 8'd5);
    exp_cnt = '{14, 3, 18, 19, 255};
    check_counts("refill_bad");

    // Asynchronous reset while a coin is waiting for ready
    @(negedge clk);
    change_in = 16'd200; coin_ready = 1'b0;
    @(negedge clk);
    change_in = '0;
    @(negedge clk);
    check_val("pre_rst_valid", coin_valid, 1);
    check_val("pre_rst_coin", coin_out, 200);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", coin_valid, 0);
    check_val("arst_coin_out", coin_out, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_state", int'(dut.state_reg), int'(ST_IDLE));
    exp_cnt = '{20, 20, 20, 20, 20};
    check_counts("arst");
    $display("reset asserted during issue");
    @(negedge clk);
    rst = 1'b0;

    exp_seq = '{20, 10};
    run_req(16'd30, 0, 16'd0, 16'd0);
    check_seq("g30");
    check_val("g30_done", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
